// File: rtl/alu_pkg.sv
// alu_pkg -- shared definitions for the sequential ALU.
// Holds the opcode constants, the controller state encoding and the
// operation select handed to the iterative multiply/divide unit.
package alu_pkg;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_CLZ  = 4'd1;
   localparam logic [3:0] OP_LSL  = 4'd2;
   localparam logic [3:0] OP_AND  = 4'd3;
   localparam logic [3:0] OP_OR   = 4'd4;
   localparam logic [3:0] OP_NOT  = 4'd5;
   localparam logic [3:0] OP_XOR  = 4'd6;
   localparam logic [3:0] OP_EQ   = 4'd7;
   localparam logic [3:0] OP_MUL  = 4'd8;
   localparam logic [3:0] OP_DIVU = 4'd9;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC,
      ST_PUSH,
      ST_NEXT
   } state_t;

   typedef enum logic {
      MD_MUL,
      MD_DIV
   } muldiv_op_t;

endpackage

// File: rtl/alu_muldiv.sv
// alu_muldiv -- iterative unsigned multiply / restoring divide, one bit
// per clock, WIDTH clocks per operation.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           load operands and begin (single-cycle pulse)
//   mode            MD_MUL or MD_DIV
//   in1, in2        MUL: in1*in2; DIV: in2 / in1
//   done            high during the final iteration cycle
//   res_lo, res_hi  value the final iteration produces (valid with done):
//                   MUL low/high product, DIV quotient/remainder
module alu_muldiv
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  muldiv_op_t       mode,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   output logic             done,
   output logic [WIDTH-1:0] res_lo,
   output logic [WIDTH-1:0] res_hi
);

   localparam int CW = $clog2(WIDTH);

   logic             active;
   muldiv_op_t       mode_q;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic [WIDTH-1:0] m;

   logic [WIDTH:0]   prod_sum;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH-1:0] div_diff;
   logic             no_borrow;
   logic [WIDTH-1:0] step_hi;
   logic [WIDTH-1:0] step_lo;

   // One iteration. Both algorithms share the {hi,lo} pair: multiply
   // shifts right, adding the multiplicand when the multiplier LSB is set;
   // divide shifts the dividend left into the remainder and subtracts the
   // divisor when it fits. A zero divisor always "fits", which yields an
   // all-ones quotient and leaves the dividend as the remainder.
   always_comb begin
      prod_sum  = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
      div_shift = {hi, lo[WIDTH-1]};
      no_borrow = (div_shift >= {1'b0, m});
      div_diff  = div_shift[WIDTH-1:0] - m;
      step_hi   = hi;
      step_lo   = lo;
      if (mode_q == MD_MUL) begin
         step_hi = prod_sum[WIDTH:1];
         step_lo = {prod_sum[0], lo[WIDTH-1:1]};
      end else if (no_borrow) begin
         step_hi = div_diff;
         step_lo = {lo[WIDTH-2:0], 1'b1};
      end else begin
         step_hi = div_shift[WIDTH-1:0];
         step_lo = {lo[WIDTH-2:0], 1'b0};
      end
   end

   assign done   = active && (count == CW'(WIDTH - 1));
   assign res_lo = step_lo;
   assign res_hi = step_hi;

   // Iteration state: operands load on start, then one step per clock
   // until the last of WIDTH iterations retires.
   always_ff @(posedge clk) begin
      if (rst) begin
         active <= 1'b0;
         mode_q <= MD_MUL;
         count  <= '0;
         hi     <= '0;
         lo     <= '0;
         m      <= '0;
      end else if (start) begin
         active <= 1'b1;
         mode_q <= mode;
         count  <= '0;
         hi     <= '0;
         lo     <= in2;
         m      <= in1;
      end else if (active) begin
         hi    <= step_hi;
         lo    <= step_lo;
         count <= count + 1'b1;
         if (done) begin
            active <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/alu_seq.sv
// alu_seq -- sequenced ALU with push/next handshake strobes.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   enable                start request, honoured only while idle
//   in1, in2, pc          operands and current program counter
//   op_code               operation select (see alu_pkg)
//   sub, cjmp, crjmp      subtract / conditional jump / relative jump
//   out1, out2            registered primary and secondary results
//   push_result           one-cycle strobe: results final
//   next                  one-cycle strobe: sequencer may advance
//   busy                  high whenever not idle
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int MULDIV_EN = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic [WIDTH-1:0] pc,
   input  logic [3:0]       op_code,
   input  logic             sub,
   input  logic             cjmp,
   input  logic             crjmp,
   output logic [WIDTH-1:0] out1,
   output logic [WIDTH-1:0] out2,
   output logic             push_result,
   output logic             next,
   output logic             busy
);

   localparam int SHW = $clog2(WIDTH);

   state_t           state;
   state_t           next_state;
   logic             is_multi;
   logic             accept;
   logic             md_start;
   muldiv_op_t       md_mode;
   logic             md_done;
   logic [WIDTH-1:0] md_lo;
   logic [WIDTH-1:0] md_hi;

   logic [WIDTH:0]     add_sum;
   logic [2*WIDTH-1:0] lsl_wide;
   logic [WIDTH-1:0]   jump_target;
   logic [WIDTH-1:0]   clz_count;
   logic [WIDTH-1:0]   comb_lo;
   logic [WIDTH-1:0]   comb_hi;

   assign is_multi = (MULDIV_EN != 0) && ((op_code == OP_MUL) || (op_code == OP_DIVU));
   assign accept   = (state == ST_IDLE) && enable;
   assign md_start = accept && is_multi;
   assign md_mode  = (op_code == OP_DIVU) ? MD_DIV : MD_MUL;

   // Subtraction reuses the adder as ~in1 + in2 + 1, so the carry out
   // reads as "no borrow".
   assign add_sum  = {1'b0, (sub ? ~in1 : in1)} + {1'b0, in2} + (WIDTH + 1)'(sub);
   assign lsl_wide = {{WIDTH{1'b0}}, in2} << in1[SHW-1:0];
   assign jump_target = (in1 == '0) ? (crjmp ? pc + in2 : in2) : pc + WIDTH'(1);

   // Leading-zero count: scanning upward lets the highest set bit win.
   always_comb begin
      clz_count = WIDTH'(WIDTH);
      for (int i = 0; i < WIDTH; i++) begin
         if (in1[i]) begin
            clz_count = WIDTH'(WIDTH - 1 - i);
         end
      end
   end

   // Single-cycle result selection; reserved opcodes (and MUL/DIVU when
   // the iterative unit is absent) fall through to zero.
   always_comb begin
      comb_lo = '0;
      comb_hi = '0;
      case (op_code)
         OP_ADD: begin
            if (cjmp) begin
               comb_lo = jump_target;
            end else begin
               comb_lo = add_sum[WIDTH-1:0];
               comb_hi = {{(WIDTH-1){1'b0}}, add_sum[WIDTH]};
            end
         end
         OP_CLZ: comb_lo = clz_count;
         OP_LSL: begin
            comb_lo = lsl_wide[WIDTH-1:0];
            comb_hi = lsl_wide[2*WIDTH-1:WIDTH];
         end
         OP_AND: comb_lo = in1 & in2;
         OP_OR:  comb_lo = in1 | in2;
         OP_NOT: comb_lo = ~in1;
         OP_XOR: comb_lo = in1 ^ in2;
         OP_EQ:  comb_lo = {{(WIDTH-1){1'b0}}, (in1 == in2)};
         default: begin
            comb_lo = '0;
            comb_hi = '0;
         end
      endcase
   end

   // The iterative unit only exists when enabled; otherwise it never
   // reports completion and MUL/DIVU are treated as single-cycle reserved.
   generate
      if (MULDIV_EN != 0) begin : g_muldiv
         alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
            .clk    (clk),
            .rst    (rst),
            .start  (md_start),
            .mode   (md_mode),
            .in1    (in1),
            .in2    (in2),
            .done   (md_done),
            .res_lo (md_lo),
            .res_hi (md_hi)
         );
      end else begin : g_no_muldiv
         assign md_done = 1'b0;
         assign md_lo   = '0;
         assign md_hi   = '0;
      end
   endgenerate

   // Controller state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and strobe decode.
   always_comb begin
      next_state  = state;
      push_result = 1'b0;
      next        = 1'b0;
      busy        = 1'b1;
      case (state)
         ST_IDLE: begin
            busy = 1'b0;
            if (enable) begin
               next_state = is_multi ? ST_EXEC : ST_PUSH;
            end
         end
         ST_EXEC: begin
            if (md_done) begin
               next_state = ST_PUSH;
            end
         end
         ST_PUSH: begin
            push_result = 1'b1;
            next_state  = ST_NEXT;
         end
         ST_NEXT: begin
            next       = 1'b1;
            next_state = ST_IDLE;
         end
         default: next_state = ST_IDLE;
      endcase
   end

   // Result registers: single-cycle ops capture on the accepting edge,
   // iterative ops on the edge that retires their last step; otherwise hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         out1 <= '0;
         out2 <= '0;
      end else if (accept && !is_multi) begin
         out1 <= comb_lo;
         out2 <= comb_hi;
      end else if ((state == ST_EXEC) && md_done) begin
         out1 <= md_lo;
         out2 <= md_hi;
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq -- self-checking bench for alu_seq (WIDTH=32, MULDIV_EN=1).
// A cycle-timeline reference model predicts out1/out2/busy/push_result/next
// every cycle; directed cases pin literal values on top of that.
module tb_alu_seq;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          enable = 1'b0;
   logic [W-1:0]  in1 = '0;
   logic [W-1:0]  in2 = '0;
   logic [W-1:0]  pc = '0;
   logic [3:0]    op_code = 4'd0;
   logic          sub = 1'b0;
   logic          cjmp = 1'b0;
   logic          crjmp = 1'b0;
   logic [W-1:0]  out1;
   logic [W-1:0]  out2;
   logic          push_result;
   logic          next;
   logic          busy;

   int checks = 0;
   int passes = 0;
   bit cmpOn = 1'b0;

   alu_seq #(.WIDTH(W), .MULDIV_EN(1)) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .in1         (in1),
      .in2         (in2),
      .pc          (pc),
      .op_code     (op_code),
      .sub         (sub),
      .cjmp        (cjmp),
      .crjmp       (crjmp),
      .out1        (out1),
      .out2        (out2),
      .push_result (push_result),
      .next        (next),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual === expected) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Reference result {out2, out1} computed with plain wide arithmetic.
   function automatic logic [63:0] modelResult(input logic [3:0] op, input logic s, input logic cj,
                                               input logic crj, input logic [31:0] a,
                                               input logic [31:0] b, input logic [31:0] p);
      logic [63:0] r;
      logic [63:0] t;
      int n;
      r = '0;
      case (op)
         4'd0: begin
            if (cj) begin
               r = {32'h0, (a == 32'h0) ? (crj ? b + p : b) : p + 32'd1};
            end else if (s) begin
               t = {32'h0, ~a} + {32'h0, b} + 64'd1;
               r = {31'h0, t[32], t[31:0]};
            end else begin
               t = {32'h0, a} + {32'h0, b};
               r = {31'h0, t[32], t[31:0]};
            end
         end
         4'd1: begin
            n = 32;
            for (int i = 31; i >= 0; i--) begin
               if (a[i]) begin
                  n = 31 - i;
                  break;
               end
            end
            r = 64'(n);
         end
         4'd2: r = {32'h0, b} << a[4:0];
         4'd3: r = {32'h0, a & b};
         4'd4: r = {32'h0, a | b};
         4'd5: r = {32'h0, ~a};
         4'd6: r = {32'h0, a ^ b};
         4'd7: r = (a == b) ? 64'd1 : 64'd0;
         4'd8: r = {32'h0, a} * {32'h0, b};
         4'd9: r = (a == 32'h0) ? {b, 32'hFFFF_FFFF} : {b % a, b / a};
         default: r = '0;
      endcase
      return r;
   endfunction

   // Timeline model: mAge is the cycle number since acceptance. Results
   // appear in cycle lat+1 together with push_result, next follows in
   // lat+2, and the request is retired after that.
   bit          mActive = 1'b0;
   int          mAge = 0;
   int          mLat = 0;
   logic [63:0] mPend = '0;
   logic [63:0] mOut = '0;

   always @(posedge clk) begin
      if (rst) begin
         mActive = 1'b0;
         mOut    = '0;
      end else if (mActive) begin
         mAge++;
         if (mAge == mLat + 1) mOut = mPend;
         if (mAge > mLat + 2) mActive = 1'b0;
      end else if (enable) begin
         mActive = 1'b1;
         mAge    = 1;
         mLat    = (op_code == 4'd8 || op_code == 4'd9) ? W : 0;
         mPend   = modelResult(op_code, sub, cjmp, crjmp, in1, in2, pc);
         if (mLat == 0) mOut = mPend;
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (cmpOn) begin
         checkOutput("out1", {32'h0, out1}, {32'h0, mOut[31:0]});
         checkOutput("out2", {32'h0, out2}, {32'h0, mOut[63:32]});
         checkOutput("busy", {63'h0, busy}, {63'h0, mActive});
         checkOutput("push_result", {63'h0, push_result}, {63'h0, mActive && (mAge == mLat + 1)});
         checkOutput("next", {63'h0, next}, {63'h0, mActive && (mAge == mLat + 2)});
      end
   end

   // Issue one request, wait (bounded) for push_result, report its cycle.
   task automatic applyStimulus(input logic [3:0] op, input logic s, input logic cj, input logic crj,
                                input logic [31:0] a, input logic [31:0] b, input logic [31:0] p,
                                output int pushCycle);
      int cyc;
      @(negedge clk);
      op_code = op; sub = s; cjmp = cj; crjmp = crj;
      in1 = a; in2 = b; pc = p;
      enable = 1'b1;
      @(negedge clk);
      enable = 1'b0;
      cyc = 1;
      pushCycle = -1;
      for (int k = 0; k < 50; k++) begin
         if (push_result === 1'b1) begin
            pushCycle = cyc;
            break;
         end
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic finishRequest();
      @(negedge clk);
      checkOutput("next_after_push", {63'h0, next}, 64'd1);
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int pc_n;
      logic [31:0] ra;
      logic [31:0] rb;

      repeat (3) @(negedge clk);
      cmpOn = 1'b1;
      checkOutput("rst_out1", {32'h0, out1}, 64'h0);
      checkOutput("rst_busy", {63'h0, busy}, 64'h0);
      rst = 1'b0;

      applyStimulus(4'd0, 1'b1, 1'b0, 1'b0, 32'd5, 32'd3, 32'h0, pc_n);
      checkOutput("sub_push_cycle", 64'(pc_n), 64'd1);
      checkOutput("sub_out1", {32'h0, out1}, 64'hFFFF_FFFE);
      checkOutput("sub_out2", {32'h0, out2}, 64'h0);
      finishRequest();

      applyStimulus(4'd0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2, 32'h0, pc_n);
      checkOutput("add_out1", {32'h0, out1}, 64'h1);
      checkOutput("add_out2", {32'h0, out2}, 64'h1);
      finishRequest();

      applyStimulus(4'd0, 1'b1, 1'b1, 1'b1, 32'd0, 32'h10, 32'h100, pc_n);
      checkOutput("cjmp_taken", {32'h0, out1}, 64'h110);
      finishRequest();
      applyStimulus(4'd0, 1'b0, 1'b1, 1'b1, 32'd7, 32'h10, 32'h100, pc_n);
      checkOutput("cjmp_fall", {32'h0, out1}, 64'h101);
      checkOutput("cjmp_out2", {32'h0, out2}, 64'h0);
      finishRequest();

      applyStimulus(4'd8, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, pc_n);
      checkOutput("mul_push_cycle", 64'(pc_n), 64'd33);
      checkOutput("mul_out1", {32'h0, out1}, 64'h1);
      checkOutput("mul_out2", {32'h0, out2}, 64'hFFFF_FFFE);
      finishRequest();

      applyStimulus(4'd9, 1'b0, 1'b0, 1'b0, 32'd0, 32'h1234, 32'h0, pc_n);
      checkOutput("div0_out1", {32'h0, out1}, 64'hFFFF_FFFF);
      checkOutput("div0_out2", {32'h0, out2}, 64'h1234);
      checkOutput("div0_push_cycle", 64'(pc_n), 64'd33);
      finishRequest();
      applyStimulus(4'd9, 1'b0, 1'b0, 1'b0, 32'd7, 32'd100, 32'h0, pc_n);
      checkOutput("div_out1", {32'h0, out1}, 64'd14);
      checkOutput("div_out2", {32'h0, out2}, 64'd2);
      finishRequest();

      applyStimulus(4'd2, 1'b0, 1'b0, 1'b0, 32'd33, 32'h8000_0001, 32'h0, pc_n);
      checkOutput("lsl_out1", {32'h0, out1}, 64'h2);
      checkOutput("lsl_out2", {32'h0, out2}, 64'h1);
      finishRequest();
      applyStimulus(4'd1, 1'b0, 1'b0, 1'b0, 32'd0, 32'h0, 32'h0, pc_n);
      checkOutput("clz_zero", {32'h0, out1}, 64'd32);
      finishRequest();
      applyStimulus(4'd1, 1'b0, 1'b0, 1'b0, 32'h0001_0000, 32'h0, 32'h0, pc_n);
      checkOutput("clz_bit16", {32'h0, out1}, 64'd15);
      finishRequest();
      applyStimulus(4'd7, 1'b0, 1'b0, 1'b0, 32'd5, 32'd5, 32'h0, pc_n);
      checkOutput("eq_true", {32'h0, out1}, 64'd1);
      finishRequest();
      applyStimulus(4'd12, 1'b0, 1'b0, 1'b0, 32'hDEAD, 32'hBEEF, 32'h0, pc_n);
      checkOutput("reserved_out1", {32'h0, out1}, 64'h0);
      finishRequest();

      // Reset during EXEC cycle 10 of a MUL with enable held high.
      @(negedge clk);
      op_code = 4'd8; in1 = 32'h1234_5678; in2 = 32'h9ABC_DEF0; sub = 1'b0; cjmp = 1'b0;
      enable = 1'b1;
      repeat (10) @(negedge clk);
      checkOutput("abort_busy_before", {63'h0, busy}, 64'd1);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("abort_out1", {32'h0, out1}, 64'h0);
      checkOutput("abort_busy", {63'h0, busy}, 64'h0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("abort_reaccept", {63'h0, busy}, 64'd1);
      enable = 1'b0;
      repeat (40) @(negedge clk);

      // Randomized traffic with occasional resets; the model checks it all.
      for (int c = 0; c < 2500; c++) begin
         @(negedge clk);
         rst     = ($urandom_range(0, 299) == 0);
         enable  = ($urandom_range(0, 2) != 0);
         op_code = 4'($urandom_range(0, 15));
         sub     = 1'($urandom_range(0, 1));
         cjmp    = ($urandom_range(0, 3) == 0);
         crjmp   = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 4))
            0: ra = 32'h0;
            1: ra = 32'hFFFF_FFFF;
            2: ra = 32'($urandom_range(0, 15));
            default: ra = $urandom;
         endcase
         case ($urandom_range(0, 3))
            0: rb = 32'h0;
            1: rb = 32'hFFFF_FFFF;
            default: rb = $urandom;
         endcase
         in1 = ra;
         in2 = rb;
         pc  = $urandom;
      end
      @(negedge clk);
      rst = 1'b0;
      enable = 1'b0;
      repeat (40) @(negedge clk);

      cmpOn = 1'b0;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width (>=8, power of two).
REQ-002 SHALL have parameter MULDIV_EN, default 1, 1 = MUL/DIVU implemented, 0 = those opcodes behave as reserved.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  start request, sampled only while busy=0.
REQ-006 SHALL have ports in1, in2, pc  input  WIDTH each  operands and current program counter.
REQ-007 SHALL have port op_code  input  4  operation select (Function).
REQ-008 SHALL have ports sub, cjmp, crjmp  input  1 each  subtract, conditional-jump, relative-jump modifiers.
REQ-009 SHALL have ports out1, out2  output  WIDTH each  registered result low/primary and high/secondary.
REQ-010 SHALL have port push_result  output  1  one-cycle strobe: out1/out2 final, push to stack.
REQ-011 SHALL have port next  output  1  one-cycle strobe: sequencer may advance.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-013 SHALL implement FSM IDLE -> (EXEC, multi-cycle ops only) -> PUSH -> NEXT -> IDLE.
REQ-014 SHALL accept a request when enable=1 in IDLE; operands and controls latched on that edge; enable ignored in all other states.
REQ-015 Single-cycle ops: accept in cycle 0, out1/out2 updated at end of cycle 0, push_result=1 in cycle 1, next=1 in cycle 2, IDLE (accepting) in cycle 3.
REQ-016 MUL/DIVU: EXEC for exactly WIDTH cycles (1..WIDTH), out1/out2 updated at end of cycle WIDTH, push_result in cycle WIDTH+1, next in WIDTH+2; out1/out2 hold previous values during EXEC.
REQ-017 Op 0 ADD: out1 = (in1+in2) mod 2^WIDTH, out2 = carry-out zero-extended; sub=1: out1 = in2 - in1 (computed ~in1+in2+1), out2 = carry of that sum (1 = no borrow).
REQ-018 Op 0 with cjmp=1 (overrides sub): if in1==0 then out1 = crjmp ? pc+in2 : in2, else out1 = pc+1; out2 = 0; all mod 2^WIDTH.
REQ-019 Op 1 CLZ: out1 = leading zeros of in1 (WIDTH when in1=0), out2 = 0.
REQ-020 Op 2 LSL: 2*WIDTH-bit product in2 << in1[log2(WIDTH)-1:0]; out1 = low half, out2 = high half; upper in1 bits ignored.
REQ-021 Ops 3 AND, 4 OR, 6 XOR of in1,in2; op 5 NOT in1; op 7 EQ: out1 = (in1==in2) in bit 0; out2 = 0 for ops 3-7.
REQ-022 Op 8 MUL: unsigned in1*in2, out1 = low WIDTH bits, out2 = high WIDTH bits, shift-add one bit per EXEC cycle.
REQ-023 Op 9 DIVU: out1 = in2 / in1, out2 = in2 % in1, restoring, one bit per EXEC cycle; in1=0 gives out1 = all ones, out2 = in2, same latency.
REQ-024 Ops 10-15 (and 8-9 when MULDIV_EN=0): single-cycle, out1 = out2 = 0.
REQ-025 push_result and next SHALL never be high together and each SHALL be high exactly one cycle per accepted request.

Reset
REQ-026 rst=1 at a rising edge SHALL force IDLE, out1=out2=0, push_result=next=0, busy=0, clear EXEC counter/partials, regardless of state (incl. mid-EXEC); no strobe follows an aborted operation.
REQ-027 enable during a rst=1 cycle SHALL be ignored; first acceptance possible in the cycle after rst deasserts.

Structure
REQ-028 Opcode constants (OP_ADD..OP_DIVU) and FSM state encoding SHALL live in shared package alu_pkg.
REQ-029 Iterative multiply/divide SHALL be sub-module alu_muldiv (start, done, counter, partials); generated only when MULDIV_EN=1; combinational ops remain in alu_seq.

Verification (WIDTH=32)
REQ-030 ADD sub=1, in1=5, in2=3 -> out1=0xFFFFFFFE, out2=0, push_result cycle 1, next cycle 2.
REQ-031 cjmp=1 crjmp=1, in1=0, in2=0x10, pc=0x100 -> out1=0x110; same with in1=7 -> out1=0x101.
REQ-032 MUL in1=0xFFFFFFFF, in2=0xFFFFFFFF -> out1=0x00000001, out2=0xFFFFFFFE, push_result exactly cycle 33, busy=1 cycles 1-34.
REQ-033 DIVU in1=0, in2=0x1234 -> out1=0xFFFFFFFF, out2=0x1234; DIVU in1=7, in2=100 -> out1=14, out2=2.
REQ-034 LSL in1=33, in2=0x80000001 -> out1=0x00000002, out2=0x00000001; CLZ in1=0 -> 32.
REQ-035 rst asserted in EXEC cycle 10 of MUL, enable held high throughout -> outputs 0, no push_result/next; enable accepted first cycle after rst falls.
